pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the Y86-64 five-stage core. It computes the per-stage stall/bubble controls for the F, D, E, M and W pipeline registers, covering load/use, `ret`, branch-mispredict and exception hazards. A small run-state FSM sequences the whole pipeline: idle-after-reset, start, data-memory wait freeze and terminal halt. It sits beside the stage pipeline registers and drives every `*_stall_i`/`*_bubble_i` input.

## Interface
- `CNT_W`, 32, width of performance counters (used only with `PIPE_PERF_EN`)
- `clk_i` in 1 — single clock
- `rst_n_i` in 1 — reset, synchronous, active-low
- `start_i` in 1 — begin execution; sampled only in IDLE
- `D_icode_i` in 4 — icode in D register
- `d_srcA_i`, `d_srcB_i` in 4 each — decode source registers (`RNONE`=4'hF)
- `E_icode_i` in 4, `E_dstM_i` in 4 — E register icode / load destination
- `e_cnd_i` in 1 — execute condition result
- `M_icode_i` in 4, `m_stat_i` in 3 — M icode, memory-stage status
- `W_icode_i` in 4, `W_stat_i` in 3 — W icode and status
- `dmem_busy_i` in 1 — data memory not ready this cycle
- `F_stall_o`, `F_bubble_o`, `D_stall_o`, `D_bubble_o`, `E_stall_o`, `E_bubble_o`, `M_stall_o`, `M_bubble_o`, `W_stall_o`, `W_bubble_o` out 1 each
- `state_o` out 2 — IDLE=0, RUN=1, MWAIT=2, HALTED=3
- `cpu_stat_o` out 3 — terminal status latched on halt, else `SAOK`
- `cycle_cnt_o`, `instr_cnt_o`, `stall_cnt_o` out `CNT_W` (only with `PIPE_PERF_EN`)

## Operation
- Stat codes: `SBUB`=0, `SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4. Status is exceptional if it is `SHLT`, `SADR` or `SINS`.
- Memory op in M: M_icode ∈ {RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ}.
- Hazard terms:
  - `lu` = E_icode ∈ {MRMOVQ, POPQ} and E_dstM ∈ {d_srcA, d_srcB}, with E_dstM ≠ RNONE.
  - `rt` = IRET ∈ {D_icode, E_icode, M_icode}.
  - `mp` = E_icode==IJXX and !e_cnd.
  - `mx` = m_stat exceptional.
  - `wx` = W_stat exceptional.
- RUN, no freeze:
  - F_stall = lu|rt
  - D_stall = lu
  - D_bubble = mp | (!lu & rt)
  - E_bubble = mp|lu
  - M_bubble = mx|wx
  - W_stall = wx
  - All other controls 0.
- Freeze (RUN or MWAIT, memory op in M, `dmem_busy_i`=1):
  - F/D/E/M_stall=1, all bubbles 0.
  - W_bubble = !wx, W_stall = wx.
- IDLE: F_stall=1, D/E/M/W_bubble=1, all others 0 (pipeline is flushed every cycle).
- HALTED: all five stalls=1, all bubbles 0.
- Invariant: no stage ever has stall and bubble both 1.
- FSM (evaluated at the rising edge):
  - IDLE→RUN on start_i.
  - RUN→MWAIT on freeze.
  - MWAIT→RUN when dmem_busy_i=0.
  - RUN/MWAIT→HALTED when wx; `cpu_stat_o`←W_stat_i. HALTED beats MWAIT.
  - HALTED is left only by reset. start_i is ignored outside IDLE.

## Timing
- Stall/bubble outputs are combinational from the registered state and the current inputs; hazard response takes effect at the same edge.
- State, `cpu_stat_o` and counters are registered; each updates at the edge after its cause.
- Reset: while rst_n_i=0, outputs take IDLE values. After the reset edge: state=IDLE, cpu_stat_o=SAOK, counters=0.
- Reset asserted mid-MWAIT or in HALTED returns to IDLE in one edge.
- wx and freeze in the same cycle: W_stall=1, W_bubble=0, next state HALTED.

## Configuration
- `PIPE_PERF_EN` defined: three `CNT_W` wrap-around counters are present.
  - cycle_cnt increments each cycle in RUN/MWAIT.
  - instr_cnt increments when in RUN, W_stat==SAOK, W_icode≠INOP and W not stalled.
  - stall_cnt increments when F_stall=1 in RUN/MWAIT.
- Undefined: counter ports and logic are absent.

## Structure
- `y86_pkg`: icode constants (IHALT…IPOPQ), RNONE, stat codes, the `ctrl_state_t` enum.
- Sub-module `hazard_detect`: purely combinational; computes lu/rt/mp/mx/wx. The FSM, output muxing and counters stay in `pipe_ctrl`.

## Test plan
- Reset, then start_i=1 for one cycle → state_o IDLE then RUN; before start, F_stall=1 and D/E/M/W_bubble=1.
- E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
- D_icode=IRET, no lu → F_stall=1, D_bubble=1; with lu also present → D_stall=1, D_bubble=0.
- E_icode=IJXX, e_cnd=0 → D_bubble=1, E_bubble=1.
- M_icode=MRMOVQ, dmem_busy_i high 3 cycles → F/D/E/M_stall=1 and W_bubble=1 for 3 cycles; state_o=MWAIT, then RUN the cycle after busy drops.
- W_stat=SADR → W_stall=1, M_bubble=1; next cycle state_o=HALTED, cpu_stat_o=3. start_i is ignored; rst_n_i=0 returns to IDLE (counters=0 under `PIPE_PERF_EN`).

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register/stat encodings and
// the pipeline-control run-state enum.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_RUN    = 2'd1,
        CS_MWAIT  = 2'd2,
        CS_HALTED = 2'd3
    } ctrl_state_t;

    function automatic logic isExcept(input logic [2:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

    function automatic logic isMemOp(input logic [3:0] icode);
        return (icode == IRMMOVQ) || (icode == IMRMOVQ) || (icode == ICALL) ||
               (icode == IRET)    || (icode == IPUSHQ)  || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Hazard term decode for the Y86-64 pipeline: load/use, ret, mispredict, exceptions.
// Latency: purely combinational. Backpressure: none, decode only.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] dIcode,
    input  logic [3:0] dSrcA,
    input  logic [3:0] dSrcB,
    input  logic [3:0] eIcode,
    input  logic [3:0] eDstM,
    input  logic       eCnd,
    input  logic [3:0] mIcode,
    input  logic [2:0] mStat,
    input  logic [2:0] wStat,
    output logic       lu,
    output logic       rt,
    output logic       mp,
    output logic       mx,
    output logic       wx
);

    logic eIsLoad;

    assign eIsLoad = (eIcode == IMRMOVQ) || (eIcode == IPOPQ);
    // RNONE guard keeps a load with no destination from matching unused sources.
    assign lu = eIsLoad && (eDstM != RNONE) && ((eDstM == dSrcA) || (eDstM == dSrcB));
    assign rt = (dIcode == IRET) || (eIcode == IRET) || (mIcode == IRET);
    assign mp = (eIcode == IJXX) && !eCnd;
    assign mx = isExcept(mStat);
    assign wx = isExcept(wStat);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble plus IDLE/RUN/MWAIT/HALTED run FSM.
// Latency: controls combinational from state+inputs; state/status/counters register next edge.
// Backpressure: dmem_busy_i with a memory op in M freezes F..M; PIPE_PERF_EN adds perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [3:0]       W_icode_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dmem_busy_i,
    output logic             F_stall_o,
    output logic             F_bubble_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_stall_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             W_bubble_o,
    output logic [1:0]       state_o,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
`endif
    output logic [2:0]       cpu_stat_o
);

    ctrl_state_t state, stateNxt, curState;
    logic [2:0]  cpuStat;
    logic        lu, rt, mp, mx, wx;
    logic        active, freeze;

    hazard_detect uHazard (
        .dIcode (D_icode_i),
        .dSrcA  (d_srcA_i),
        .dSrcB  (d_srcB_i),
        .eIcode (E_icode_i),
        .eDstM  (E_dstM_i),
        .eCnd   (e_cnd_i),
        .mIcode (M_icode_i),
        .mStat  (m_stat_i),
        .wStat  (W_stat_i),
        .lu     (lu),
        .rt     (rt),
        .mp     (mp),
        .mx     (mx),
        .wx     (wx)
    );

    // While reset is held the outputs behave as IDLE, even before the first edge.
    assign curState = rst_n_i ? state : CS_IDLE;
    assign active   = (curState == CS_RUN) || (curState == CS_MWAIT);
    assign freeze   = active && isMemOp(M_icode_i) && dmem_busy_i;

    always_comb begin
        stateNxt   = curState;
        F_stall_o  = 1'b0;
        F_bubble_o = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_stall_o  = 1'b0;
        E_bubble_o = 1'b0;
        M_stall_o  = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        W_bubble_o = 1'b0;
        case (curState)
            CS_IDLE: begin
                F_stall_o  = 1'b1;
                D_bubble_o = 1'b1;
                E_bubble_o = 1'b1;
                M_bubble_o = 1'b1;
                W_bubble_o = 1'b1;
                if (start_i) stateNxt = CS_RUN;
            end
            CS_RUN, CS_MWAIT: begin
                if (freeze) begin
                    F_stall_o  = 1'b1;
                    D_stall_o  = 1'b1;
                    E_stall_o  = 1'b1;
                    M_stall_o  = 1'b1;
                    W_stall_o  = wx;
                    W_bubble_o = !wx;
                end else begin
                    F_stall_o  = lu | rt;
                    D_stall_o  = lu;
                    D_bubble_o = mp | (!lu & rt);
                    E_bubble_o = mp | lu;
                    M_bubble_o = mx | wx;
                    W_stall_o  = wx;
                end
                // An exception reaching W ends execution even mid-wait.
                if (wx)          stateNxt = CS_HALTED;
                else if (freeze) stateNxt = CS_MWAIT;
                else             stateNxt = CS_RUN;
            end
            default: begin
                F_stall_o = 1'b1;
                D_stall_o = 1'b1;
                E_stall_o = 1'b1;
                M_stall_o = 1'b1;
                W_stall_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= CS_IDLE;
            cpuStat <= SAOK;
        end else begin
            state <= stateNxt;
            if (active && wx) cpuStat <= W_stat_i;
        end
    end

    assign state_o    = curState;
    assign cpu_stat_o = rst_n_i ? cpuStat : SAOK;

`ifdef PIPE_PERF_EN
    logic instrRetire;

    assign instrRetire = (curState == CS_RUN) && (W_stat_i == SAOK) &&
                         (W_icode_i != INOP) && !W_stall_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cycle_cnt_o <= '0;
            instr_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (active)              cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (instrRetire)         instr_cnt_o <= instr_cnt_o + 1'b1;
            if (active && F_stall_o) stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`else
    logic unusedWIcode;
    assign unusedWIcode = ^W_icode_i;
`endif

endmodule
